// File: rtl/int_ctrl.sv
// Four-source interrupt controller: edge-latched pending/lost, one-deep IDLE/REQ/SERV handshake.
// Define INT_ROUND_ROBIN_EN for rotating priority; otherwise the lowest-index source wins.
module int_ctrl #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = PC_W'(10'h3F0)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      irq_in,
    input  logic            en_we,
    input  logic [3:0]      en_wdata,
    input  logic            cpu_ack,
    input  logic            cpu_eoi,
    input  logic            lost_clr,
    output logic            cpu_irq,
    output logic [PC_W-1:0] vector,
    output logic [1:0]      irq_id,
    output logic            in_service,
    output logic [3:0]      pending,
    output logic [3:0]      lost
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t          state_q, state_d;
    logic [3:0]      irq_q, irq_d;
    logic [3:0]      pending_q, pending_d;
    logic [3:0]      lost_q, lost_d;
    logic [3:0]      enable_q, enable_d;
    logic [1:0]      irq_id_q, irq_id_d;
    logic [PC_W-1:0] vector_q, vector_d;
    logic            cpu_irq_q, cpu_irq_d;
    logic            in_service_q, in_service_d;
`ifdef INT_ROUND_ROBIN_EN
    logic [1:0]      last_q, last_d;
    logic [1:0]      idx;
`endif

    logic [3:0] edge_v, clr_v, lost_set, req_v;
    logic [1:0] win;
    logic       ack_fire;

    always_comb begin
        irq_d    = irq_in;
        edge_v   = irq_in & ~irq_q;
        ack_fire = (state_q == REQ) && cpu_ack;
        clr_v    = ack_fire ? (4'b0001 << irq_id_q) : 4'b0000;
        // A fresh edge on the acked source re-arms it rather than counting as an overflow.
        lost_set  = edge_v & pending_q & ~clr_v;
        pending_d = (pending_q & ~clr_v) | edge_v;
        lost_d    = (lost_clr ? 4'b0000 : lost_q) | lost_set;
        enable_d  = en_we ? en_wdata : enable_q;
        req_v     = pending_q & enable_q;

        win = 2'd0;
`ifdef INT_ROUND_ROBIN_EN
        idx    = 2'd0;
        last_d = ack_fire ? irq_id_q : last_q;
        // Descending offset so the source nearest after last_served wins.
        for (int k = 3; k >= 0; k--) begin
            idx = last_q + 2'd1 + 2'(k);
            if (req_v[idx]) win = idx;
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (req_v[i]) win = 2'(i);
        end
`endif

        state_d  = state_q;
        irq_id_d = irq_id_q;
        vector_d = vector_q;
        case (state_q)
            IDLE: begin
                if (req_v != 4'b0000) begin
                    state_d  = REQ;
                    irq_id_d = win;
                    vector_d = VEC_BASE + PC_W'({win, 2'b00});
                end
            end
            REQ: begin
                if (cpu_ack)
                    state_d = SERV;
                else if (en_we && !en_wdata[irq_id_q])
                    state_d = IDLE;
            end
            SERV: begin
                if (cpu_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_irq_d    = (state_d == REQ);
        in_service_d = (state_d == SERV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_q        <= 4'b0000;
            pending_q    <= 4'b0000;
            lost_q       <= 4'b0000;
            enable_q     <= 4'b0000;
            irq_id_q     <= 2'd0;
            vector_q     <= VEC_BASE;
            cpu_irq_q    <= 1'b0;
            in_service_q <= 1'b0;
`ifdef INT_ROUND_ROBIN_EN
            last_q       <= 2'd3;
`endif
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            lost_q       <= lost_d;
            enable_q     <= enable_d;
            irq_id_q     <= irq_id_d;
            vector_q     <= vector_d;
            cpu_irq_q    <= cpu_irq_d;
            in_service_q <= in_service_d;
`ifdef INT_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign cpu_irq    = cpu_irq_q;
    assign vector     = vector_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expected presentations queued at stimulus time, popped when cpu_irq rises.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_in = 4'b0;
    logic       en_we = 1'b0;
    logic [3:0] en_wdata = 4'b0;
    logic       cpu_ack = 1'b0;
    logic       cpu_eoi = 1'b0;
    logic       lost_clr = 1'b0;
    logic       cpu_irq;
    logic [9:0] vector;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] lost;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] id;
        logic [9:0] vec;
    } exp_t;
    exp_t sb[$];

    int_ctrl #(.PC_W(10), .VEC_BASE(10'h3F0)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .en_we(en_we), .en_wdata(en_wdata),
        .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .lost_clr(lost_clr), .cpu_irq(cpu_irq),
        .vector(vector), .irq_id(irq_id), .in_service(in_service), .pending(pending), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] id);
        exp_t e;
        e.id  = id;
        e.vec = 10'h3F0 + {6'd0, id, 2'b00};
        sb.push_back(e);
    endtask

    // Waits (bounded) for a presentation and compares it with the oldest queued expectation.
    task automatic present_check(input string tag);
        exp_t e;
        for (int n = 0; n < 8 && cpu_irq !== 1'b1; n++) step();
        chk({tag, "_irq"}, {31'd0, cpu_irq}, 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_id"}, {30'd0, irq_id}, {30'd0, e.id});
            chk({tag, "_vec"}, {22'd0, vector}, {22'd0, e.vec});
        end
    endtask

    task automatic ack();
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
    endtask

    task automatic eoi();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; irq_in = 4'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0; lost_clr = 1'b0; en_we = 1'b0;
        step();
        chk("rst_irq", {31'd0, cpu_irq}, 32'd0);
        chk("rst_srv", {31'd0, in_service}, 32'd0);
        chk("rst_pend", {28'd0, pending}, 32'd0);
        chk("rst_lost", {28'd0, lost}, 32'd0);
        chk("rst_id", {30'd0, irq_id}, 32'd0);
        reset = 1'b0;
        en_we = 1'b1; en_wdata = 4'hF; step(); en_we = 1'b0;
    endtask

    initial begin
        // Single source: exact two-edge latency and vector.
        do_reset();
        irq_in = 4'b0100; step();
        chk("lat_pend", {28'd0, pending}, 32'h4);
        chk("lat_irq0", {31'd0, cpu_irq}, 32'd0);
        step();
        chk("lat_irq1", {31'd0, cpu_irq}, 32'd1);
        push(2'd2); present_check("s2");
        ack();
        chk("s2_ack_irq", {31'd0, cpu_irq}, 32'd0);
        chk("s2_ack_srv", {31'd0, in_service}, 32'd1);
        chk("s2_ack_pend", {28'd0, pending}, 32'd0);
        eoi();
        chk("s2_eoi_srv", {31'd0, in_service}, 32'd0);
        irq_in = 4'b0;

        // Simultaneous 3 and 1; REQ holds id even when 0 arrives.
        do_reset();
        irq_in = 4'b1010; step();
        push(2'd1); push(2'd3);
        present_check("p1");
        ack(); chk("p1_pend", {28'd0, pending}, 32'h8);
        eoi();
        present_check("p3");
        irq_in = 4'b1011; step();
        chk("hold_id", {30'd0, irq_id}, 32'd3);
        chk("hold_vec", {22'd0, vector}, 32'h3FC);
        chk("hold_irq", {31'd0, cpu_irq}, 32'd1);
        ack(); eoi();
        push(2'd0); present_check("p0");
        ack(); eoi();
        irq_in = 4'b0;

        // Priority after serving 0 with 0 and 1 both pending again.
        do_reset();
        irq_in = 4'b0011; step();
        push(2'd0); present_check("pr_a");
        ack();
        irq_in = 4'b0010; step();
        irq_in = 4'b0011; step();
        chk("pr_pend", {28'd0, pending}, 32'h3);
        eoi();
`ifdef INT_ROUND_ROBIN_EN
        push(2'd1); push(2'd0);
`else
        push(2'd0); push(2'd1);
`endif
        present_check("pr_b"); ack(); eoi();
        present_check("pr_c"); ack(); eoi();
        irq_in = 4'b0;

        // Overflow, lost clear, single ack, and edge coinciding with ack.
        do_reset();
        irq_in = 4'b0001; step();
        push(2'd0); present_check("ov");
        irq_in = 4'b0000; step();
        irq_in = 4'b0001; step();
        chk("ov_lost", {28'd0, lost}, 32'h1);
        chk("ov_pend", {28'd0, pending}, 32'h1);
        lost_clr = 1'b1; step(); lost_clr = 1'b0;
        chk("ov_lclr", {28'd0, lost}, 32'h0);
        irq_in = 4'b0000; step();
        ack(); chk("ov_ack_pend", {28'd0, pending}, 32'h0);
        eoi();
        irq_in = 4'b0001; step();
        push(2'd0); present_check("co");
        irq_in = 4'b0000; step();
        irq_in = 4'b0001; cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        chk("co_pend", {28'd0, pending}, 32'h1);
        chk("co_lost", {28'd0, lost}, 32'h0);
        chk("co_srv", {31'd0, in_service}, 32'd1);
        eoi();
        push(2'd0); present_check("co2");
        ack(); eoi();
        irq_in = 4'b0;

        // Disable while requesting, re-enable, then ack beats disable.
        do_reset();
        irq_in = 4'b0010; step();
        push(2'd1); present_check("dis");
        en_we = 1'b1; en_wdata = 4'h0; step(); en_we = 1'b0;
        chk("dis_irq", {31'd0, cpu_irq}, 32'd0);
        chk("dis_pend", {28'd0, pending}, 32'h2);
        step();
        chk("dis_irq2", {31'd0, cpu_irq}, 32'd0);
        en_we = 1'b1; en_wdata = 4'hF; step(); en_we = 1'b0;
        push(2'd1); present_check("ren");
        en_we = 1'b1; en_wdata = 4'h0; cpu_ack = 1'b1; step(); en_we = 1'b0; cpu_ack = 1'b0;
        chk("ackwin_srv", {31'd0, in_service}, 32'd1);
        chk("ackwin_pend", {28'd0, pending}, 32'h0);
        eoi();
        irq_in = 4'b0;

        // Asynchronous reset in SERV.
        do_reset();
        irq_in = 4'b1000; step();
        push(2'd3); present_check("ar");
        ack();
        irq_in = 4'b1100; step();
        chk("ar_srv", {31'd0, in_service}, 32'd1);
        chk("ar_pend", {28'd0, pending}, 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("ar_srv0", {31'd0, in_service}, 32'd0);
        chk("ar_irq0", {31'd0, cpu_irq}, 32'd0);
        chk("ar_pend0", {28'd0, pending}, 32'h0);
        irq_in = 4'b0;
        step();
        reset = 1'b0;

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_left observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter PC_W, default 10: program-counter width and width of vector.
REQ-002 Parameter VEC_BASE, default 10'h3F0: address of the source-0 handler.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq_in  input  4  interrupt lines from the port sources; rising edge = request; bit 0 = port i1 ... bit 3 = port i4.
REQ-006 en_we  input  1  write strobe for the enable register.
REQ-007 en_wdata  input  4  new enable value; 1 = source enabled.
REQ-008 cpu_ack  input  1  CPU accepts the presented interrupt (jump to vector this cycle).
REQ-009 cpu_eoi  input  1  CPU end-of-interrupt (return from handler).
REQ-010 lost_clr  input  1  clears the lost register.
REQ-011 cpu_irq  output  1  interrupt request to the CPU control unit.
REQ-012 vector  output  PC_W  handler address; valid while cpu_irq=1.
REQ-013 irq_id  output  2  index of the source presented or in service.
REQ-014 in_service  output  1  a handler is executing.
REQ-015 pending  output  4  latched, not yet accepted requests.
REQ-016 lost  output  4  sticky: an edge arrived while that source was already pending.

Function
REQ-017 Edge detect SHALL use a registered copy irq_q; an edge on bit i at clock edge k is irq_in[i]=1 and irq_q[i]=0 sampled at k.
REQ-018 An edge on bit i SHALL set pending[i] at edge k; if pending[i] was already 1, it SHALL set lost[i] instead.
REQ-019 FSM states: IDLE, REQ, SERV; reset state IDLE.
REQ-020 IDLE: if (pending & enable) != 0, latch winner into irq_id and go to REQ at the next edge; otherwise stay.
REQ-021 REQ: cpu_irq=1; vector = VEC_BASE + {irq_id, 2'b00} (modulo 2^PC_W); irq_id and vector SHALL NOT change while in REQ, even if a higher-priority request arrives.
REQ-022 REQ with cpu_ack=1: clear pending[irq_id] and go to SERV; cpu_irq=0 from the next cycle.
REQ-023 REQ with cpu_ack=0 and enable[irq_id] cleared by en_we: return to IDLE with pending retained; if cpu_ack=1 in the same cycle, the ack wins.
REQ-024 SERV: in_service=1; cpu_eoi=1 returns to IDLE; no new request presented before that (no nesting).
REQ-025 cpu_ack outside REQ and cpu_eoi outside SERV SHALL be ignored.
REQ-026 If a new edge on source irq_id coincides with the acking cycle, pending[irq_id] SHALL remain 1 (set wins over clear) and lost SHALL NOT be set.
REQ-027 Fixed priority: the lowest-index enabled pending source wins.
REQ-028 Latency: edge sampled at k -> pending at k -> cpu_irq=1 after edge k+1, provided the FSM was in IDLE at k.
REQ-029 lost_clr SHALL clear lost at the next edge; a coincident edge-overflow event takes precedence over the clear.
REQ-030 en_we SHALL update enable at the next edge; masked sources still latch pending.

Reset
REQ-031 On reset: state IDLE, pending=0, lost=0, enable=4'b0000, irq_q=0, irq_id=0, cpu_irq=0, in_service=0, and round-robin pointer=3.
REQ-032 Reset SHALL take effect immediately, including mid-REQ or mid-SERV, dropping cpu_irq without an ack.

Configuration
REQ-033 INT_ROUND_ROBIN_EN defined: priority rotates; search starts at (last_served+1) mod 4; last_served updates on each cpu_ack; reset value of last_served is 3, giving source 0 first priority.
REQ-034 INT_ROUND_ROBIN_EN undefined: fixed priority per REQ-027; last_served pointer absent.

Verification
REQ-035 Reset, en=4'hF, irq_in[2] rises -> cpu_irq=1 two edges later, irq_id=2, vector=10'h3F8.
REQ-036 irq_in[3] and irq_in[1] rise together -> id 1 presented first; ack then eoi -> id 3 presented (vector 10'h3FC).
REQ-037 Round-robin build: sources 0 and 1 held pending repeatedly; serve 0 -> next winner is 1, not 0. Fixed build: 0 wins again.
REQ-038 Two edges on irq_in[0] before ack -> lost=4'b0001; lost_clr -> lost=0; a single ack clears pending[0].
REQ-039 In REQ, en_wdata=0 written -> cpu_irq drops, pending kept; re-enable -> same id presented again.
REQ-040 reset asserted in SERV -> in_service=0, cpu_irq=0, pending=0 immediately, without waiting for clk.
